// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared definitions for the reset sequencer: FSM state encoding, default
// timing parameters, restart counter width, and a small helper used to size
// the internal counters.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int DEF_N_DOMAINS    = 3;
  localparam int DEF_LOCK_CYCLES  = 32;
  localparam int DEF_HOLD_CYCLES  = 16;
  localparam int DEF_STAGE_CYCLES = 8;
  localparam int RESTART_CNT_W    = 8;

  // Largest of three values; used so one counter width covers every timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Groups the sequencer's functional signals.
//   pll_lock_In      : PLL lock, asynchronous to the sequencer clock
//   sw_rst_req_In    : software reset request, sampled as a level every cycle
//   rst_n_out        : per-domain active-low resets (registered)
//   seq_done_out     : high while every domain is released
//   state_out        : current sequencer state (debug visibility)
//   restart_cnt_out  : saturating count of fault-triggered restarts
// Signal semantics: there is no valid/ready handshake here. Inputs are plain
// levels observed on every rising clock edge; outputs are registered levels
// that change only on a rising edge or on asynchronous reset.
// Modports: master = the system side driving lock/request and observing
// resets; slave = the sequencer itself.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS = DEF_N_DOMAINS
);
  logic                     pll_lock_In;
  logic                     sw_rst_req_In;
  logic [N_DOMAINS-1:0]     rst_n_out;
  logic                     seq_done_out;
  logic [1:0]               state_out;
  logic [RESTART_CNT_W-1:0] restart_cnt_out;

  modport master (
    output pll_lock_In, sw_rst_req_In,
    input  rst_n_out, seq_done_out, state_out, restart_cnt_out
  );

  modport slave (
    input  pll_lock_In, sw_rst_req_In,
    output rst_n_out, seq_done_out, state_out, restart_cnt_out
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two destination edges of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Waits for a stable, synchronized PLL lock, holds every downstream reset
// domain for a minimum time, then releases the domains one at a time in index
// order. Losing lock or a software request re-asserts every domain at once
// and restarts the sequence.
//   clk_In   : system clock, all logic on the rising edge
//   rst_n_In : asynchronous active-low reset (from the power-on generator)
//   bus      : reset_sequencer_if.slave (lock, sw request, domain resets,
//              done flag, state and restart count)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS    = DEF_N_DOMAINS,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int STAGE_CYCLES = DEF_STAGE_CYCLES
) (
  input  logic                clk_In,
  input  logic                rst_n_In,
  reset_sequencer_if.slave    bus
);
  localparam int CNT_W = $clog2(max3(LOCK_CYCLES, HOLD_CYCLES, STAGE_CYCLES) + 1);
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DOMAINS - 1);
  localparam logic [RESTART_CNT_W-1:0] RESTART_MAX = '1;

  logic                     lock_s;
  logic                     fault;
  seq_state_e               state;
  logic [CNT_W-1:0]         lock_cnt;
  logic [CNT_W-1:0]         hold_cnt;
  logic [CNT_W-1:0]         stage_cnt;
  logic [IDX_W-1:0]         idx;
  logic [N_DOMAINS-1:0]     rst_n_r;
  logic                     seq_done_r;
  logic [RESTART_CNT_W-1:0] restart_cnt;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk_In),
    .rst_n (rst_n_In),
    .d     (bus.pll_lock_In),
    .q     (lock_s)
  );

  // A fault only exists once lock has qualified; in WAIT_LOCK the same
  // conditions merely restart the lock qualification without counting.
  assign fault = (state != WAIT_LOCK) && (!lock_s || bus.sw_rst_req_In);

  always_ff @(posedge clk_In or negedge rst_n_In) begin
    if (!rst_n_In) begin
      state       <= WAIT_LOCK;
      lock_cnt    <= '0;
      hold_cnt    <= '0;
      stage_cnt   <= '0;
      idx         <= '0;
      rst_n_r     <= '0;
      seq_done_r  <= 1'b0;
      restart_cnt <= '0;
    end else if (fault) begin
      // Fault takes priority over any release or transition due this edge.
      state      <= WAIT_LOCK;
      lock_cnt   <= '0;
      hold_cnt   <= '0;
      stage_cnt  <= '0;
      idx        <= '0;
      rst_n_r    <= '0;
      seq_done_r <= 1'b0;
      if (restart_cnt != RESTART_MAX) restart_cnt <= restart_cnt + 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!lock_s || bus.sw_rst_req_In) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            state    <= HOLD;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt   <= '0;
            stage_cnt  <= '0;
            rst_n_r[0] <= 1'b1;
            idx        <= IDX_W'(1);
            if (N_DOMAINS == 1) begin
              state      <= RUN;
              seq_done_r <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_cnt    <= '0;
            rst_n_r[idx] <= 1'b1;
            if (idx == IDX_LAST) begin
              state      <= RUN;
              seq_done_r <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end
        default: ; // RUN: outputs held until a fault
      endcase
    end
  end

  assign bus.rst_n_out       = rst_n_r;
  assign bus.seq_done_out    = seq_done_r;
  assign bus.state_out       = state;
  assign bus.restart_cnt_out = restart_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed bench for reset_sequencer with default parameters. Edges are
// counted from 1 = first rising edge with rst_n high; expected release edges
// and restart counts are pushed into exp_q when stimulus is applied and
// popped when the DUT produces the corresponding output.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int N    = DEF_N_DOMAINS;
  localparam int L    = DEF_LOCK_CYCLES;
  localparam int H    = DEF_HOLD_CYCLES;
  localparam int S    = DEF_STAGE_CYCLES;
  localparam int BASE = 2 + L + H;  // edge at which domain 0 releases

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  reset_sequencer_if #(.N_DOMAINS(N)) bus ();

  reset_sequencer #(
    .N_DOMAINS    (N),
    .LOCK_CYCLES  (L),
    .HOLD_CYCLES  (H),
    .STAGE_CYCLES (S)
  ) dut (
    .clk_In   (clk),
    .rst_n_In (rst_n),
    .bus      (bus)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_edge(input int e);
    int guard = 0;
    while (edge_cnt < e && guard < 100000) begin
      next_edge();
      guard++;
    end
  endtask

  task automatic do_reset(input logic lock);
    rst_n = 1'b0;
    bus.pll_lock_In   = lock;
    bus.sw_rst_req_In = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;   // next rising edge is edge 1
  endtask

  task automatic push_seq(input int first_edge);
    for (int k = 0; k < N; k++) exp_q.push_back(32'(first_edge + k * S));
  endtask

  task automatic wait_rise(input int k, input string tag);
    int guard = 0;
    logic [31:0] e;
    while (bus.rst_n_out[k] !== 1'b1 && guard < 200) begin
      next_edge();
      guard++;
    end
    if (guard >= 200) chk({tag, "_timeout"}, 32'(0), 32'(1));
    e = exp_q.pop_front();
    chk({tag, "_edge"}, 32'(edge_cnt), e);
    chk({tag, "_vec"},  32'(bus.rst_n_out), 32'((1 << (k + 1)) - 1));
    chk({tag, "_done"}, 32'(bus.seq_done_out), 32'(k == N - 1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rst_n_out"}, 32'(bus.rst_n_out), 32'(0));
    chk({tag, "_done"},      32'(bus.seq_done_out), 32'(0));
    chk({tag, "_state"},     32'(bus.state_out), 32'(WAIT_LOCK));
    chk({tag, "_restart"},   32'(bus.restart_cnt_out), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int guard;
    bus.pll_lock_In   = 1'b1;
    bus.sw_rst_req_In = 1'b0;

    // A: power-up with lock already high
    repeat (2) @(negedge clk);
    #1 check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    goto_edge(2 + L);
    chk("a_hold_state", 32'(bus.state_out), 32'(HOLD));
    chk("a_hold_vec",   32'(bus.rst_n_out), 32'(0));
    push_seq(BASE);
    wait_rise(0, "a_d0");
    chk("a_release_state", 32'(bus.state_out), 32'(RELEASE));
    wait_rise(1, "a_d1");
    wait_rise(2, "a_d2");
    chk("a_run_state", 32'(bus.state_out), 32'(RUN));
    chk("a_restart",   32'(bus.restart_cnt_out), 32'(0));

    // Lock drop in RUN: low sampled by the first sync flop at edge 100
    goto_edge(99);
    @(negedge clk) bus.pll_lock_In = 1'b0;
    goto_edge(101);
    chk("drop_e101_vec", 32'(bus.rst_n_out), 32'(7));
    goto_edge(103);
    chk("drop_vec",     32'(bus.rst_n_out), 32'(0));
    chk("drop_done",    32'(bus.seq_done_out), 32'(0));
    chk("drop_state",   32'(bus.state_out), 32'(WAIT_LOCK));
    chk("drop_restart", 32'(bus.restart_cnt_out), 32'(1));
    goto_edge(109);
    @(negedge clk) bus.pll_lock_In = 1'b1;  // first high sample at edge 110
    push_seq(110 + 1 + L + H);
    wait_rise(0, "relock_d0");
    wait_rise(1, "relock_d1");
    wait_rise(2, "relock_d2");
    chk("relock_restart", 32'(bus.restart_cnt_out), 32'(1));

    // B: one-cycle lock glitch sampled at edge 20 during WAIT_LOCK
    do_reset(1'b1);
    goto_edge(19);
    @(negedge clk) bus.pll_lock_In = 1'b0;
    goto_edge(20);
    @(negedge clk) bus.pll_lock_In = 1'b1;
    push_seq(BASE + 20);
    wait_rise(0, "glitch_d0");
    wait_rise(1, "glitch_d1");
    wait_rise(2, "glitch_d2");
    chk("glitch_restart", 32'(bus.restart_cnt_out), 32'(0));

    // C: software request on the edge domain 1 would release
    do_reset(1'b1);
    goto_edge(57);
    @(negedge clk) bus.sw_rst_req_In = 1'b1;
    goto_edge(58);
    chk("sw_e58_vec",   32'(bus.rst_n_out), 32'(0));
    chk("sw_e58_state", 32'(bus.state_out), 32'(WAIT_LOCK));
    @(negedge clk) bus.sw_rst_req_In = 1'b0;
    goto_edge(59);
    chk("sw_e59_vec",     32'(bus.rst_n_out), 32'(0));
    chk("sw_e59_done",    32'(bus.seq_done_out), 32'(0));
    chk("sw_e59_state",   32'(bus.state_out), 32'(WAIT_LOCK));
    chk("sw_e59_restart", 32'(bus.restart_cnt_out), 32'(1));
    push_seq(58 + L + H);
    wait_rise(0, "sw_d0");
    wait_rise(1, "sw_d1");
    wait_rise(2, "sw_d2");
    chk("sw_restart_kept", 32'(bus.restart_cnt_out), 32'(1));

    // D: 300 software restarts, each after RUN, saturating at 255
    do_reset(1'b1);
    for (int i = 1; i <= 300; i++) begin
      guard = 0;
      while (bus.state_out !== RUN && guard < 200) begin
        next_edge();
        guard++;
      end
      if (guard >= 200) begin
        chk("sat_run_timeout", 32'(0), 32'(1));
        break;
      end
      @(negedge clk) bus.sw_rst_req_In = 1'b1;
      exp_q.push_back(32'((i > 255) ? 255 : i));
      @(negedge clk) bus.sw_rst_req_In = 1'b0;
      chk($sformatf("sat_restart_%0d", i), 32'(bus.restart_cnt_out), exp_q.pop_front());
    end

    // E: async reset mid-RELEASE, then a fresh sequence
    do_reset(1'b1);
    goto_edge(52);
    chk("e_pre_vec",   32'(bus.rst_n_out), 32'(1));
    chk("e_pre_state", 32'(bus.state_out), 32'(RELEASE));
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_seq(BASE);
    wait_rise(0, "e_d0");
    wait_rise(1, "e_d1");
    wait_rise(2, "e_d2");
    chk("e_restart", 32'(bus.restart_cnt_out), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
